// File: rtl/serial_to_parallel.sv
// serial_to_parallel: gathers serial signed samples into rows of LANES words for the row DCT.
//
// The first sample of a row lands in lane z0. There are two row registers: a fill register that
// collects samples and an output register that presents the finished row. Each side uses a
// valid/ready handshake. A row counter tracks the position inside an 8x8 block so that the last
// row can be tagged.
//
// Ports:
//   sys_clk, sys_rst_n      clock (rising edge), asynchronous active-low reset
//   pix_data/valid/sob      serial sample input; sob marks row 0, lane 0 of a block
//   pix_ready               sample accepted when pix_valid & pix_ready
//   DCT_data_i_z0..z7       registered parallel row (the lane ports assume LANES == 8)
//   row_valid/ready/last    output row handshake; last tags row LANES-1 of a block
//   sync_err                one-cycle pulse when sob arrives mid-row or mid-block
module serial_to_parallel #(
    parameter int unsigned DATA_W = 12,
    parameter int unsigned LANES  = 8
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic [DATA_W-1:0] pix_data,
    input  logic              pix_valid,
    input  logic              pix_sob,
    output logic              pix_ready,
    output logic [DATA_W-1:0] DCT_data_i_z0,
    output logic [DATA_W-1:0] DCT_data_i_z1,
    output logic [DATA_W-1:0] DCT_data_i_z2,
    output logic [DATA_W-1:0] DCT_data_i_z3,
    output logic [DATA_W-1:0] DCT_data_i_z4,
    output logic [DATA_W-1:0] DCT_data_i_z5,
    output logic [DATA_W-1:0] DCT_data_i_z6,
    output logic [DATA_W-1:0] DCT_data_i_z7,
    output logic              row_valid,
    input  logic              row_ready,
    output logic              row_last,
    output logic              sync_err
);

    localparam int unsigned     CntW    = (LANES > 1) ? $clog2(LANES) : 1;
    localparam logic [CntW-1:0] LastIdx = CntW'(LANES - 1);

    logic [LANES-1:0][DATA_W-1:0] fill_q, fill_d;
    logic [LANES-1:0][DATA_W-1:0] out_q, out_d;
    logic [CntW-1:0]              lane_cnt_q, lane_cnt_d;
    logic [CntW-1:0]              row_cnt_q, row_cnt_d;
    logic                         fill_full_q, fill_full_d;
    logic                         fill_last_q, fill_last_d;
    logic                         row_valid_q, row_valid_d;
    logic                         row_last_q, row_last_d;
    logic                         sync_err_q, sync_err_d;

    logic            accept;
    logic            drain;
    logic            out_free;
    logic            row_done;
    logic [CntW-1:0] wr_lane;
    logic [CntW-1:0] cur_row;

    always_comb begin
        accept   = pix_valid & ~fill_full_q;
        drain    = row_valid_q & row_ready;
        out_free = ~row_valid_q | drain;
        // sob restarts both the row and the block, discarding any partial row in fill.
        wr_lane  = pix_sob ? '0 : lane_cnt_q;
        cur_row  = pix_sob ? '0 : row_cnt_q;
        row_done = accept & (wr_lane == LastIdx);

        fill_d     = fill_q;
        lane_cnt_d = lane_cnt_q;
        row_cnt_d  = row_cnt_q;
        if (accept) begin
            fill_d[wr_lane] = pix_data;
            lane_cnt_d      = row_done ? '0 : wr_lane + 1'b1;
            row_cnt_d       = cur_row;
            if (row_done) begin
                row_cnt_d = (cur_row == LastIdx) ? '0 : cur_row + 1'b1;
            end
        end

        sync_err_d = accept & pix_sob & ((lane_cnt_q != '0) | (row_cnt_q != '0));

        out_d       = out_q;
        row_valid_d = row_valid_q;
        row_last_d  = row_last_q;
        fill_full_d = fill_full_q;
        fill_last_d = fill_last_q;
        if (fill_full_q) begin
            // Parked row moves over as soon as the consumer takes the current one.
            if (drain) begin
                out_d       = fill_q;
                row_last_d  = fill_last_q;
                fill_full_d = 1'b0;
            end
        end else if (row_done) begin
            if (out_free) begin
                // Load includes the sample being accepted on this edge.
                out_d       = fill_d;
                row_valid_d = 1'b1;
                row_last_d  = (cur_row == LastIdx);
            end else begin
                fill_full_d = 1'b1;
                fill_last_d = (cur_row == LastIdx);
            end
        end else if (drain) begin
            row_valid_d = 1'b0;
        end
    end

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            fill_q      <= '0;
            out_q       <= '0;
            lane_cnt_q  <= '0;
            row_cnt_q   <= '0;
            fill_full_q <= 1'b0;
            fill_last_q <= 1'b0;
            row_valid_q <= 1'b0;
            row_last_q  <= 1'b0;
            sync_err_q  <= 1'b0;
        end else begin
            fill_q      <= fill_d;
            out_q       <= out_d;
            lane_cnt_q  <= lane_cnt_d;
            row_cnt_q   <= row_cnt_d;
            fill_full_q <= fill_full_d;
            fill_last_q <= fill_last_d;
            row_valid_q <= row_valid_d;
            row_last_q  <= row_last_d;
            sync_err_q  <= sync_err_d;
        end
    end

    assign pix_ready     = ~fill_full_q;
    assign row_valid     = row_valid_q;
    assign row_last      = row_last_q;
    assign sync_err      = sync_err_q;
    assign DCT_data_i_z0 = out_q[0];
    assign DCT_data_i_z1 = out_q[1];
    assign DCT_data_i_z2 = out_q[2];
    assign DCT_data_i_z3 = out_q[3];
    assign DCT_data_i_z4 = out_q[4];
    assign DCT_data_i_z5 = out_q[5];
    assign DCT_data_i_z6 = out_q[6];
    assign DCT_data_i_z7 = out_q[7];

endmodule

// File: tb/tb_serial_to_parallel.sv
// Directed bench for serial_to_parallel: fill, full block, backpressure, resync, reset, edge drain.
module tb_serial_to_parallel;

    logic        clk;
    logic        rst_n;
    logic [11:0] pix_data;
    logic        pix_valid;
    logic        pix_sob;
    logic        pix_ready;
    logic [11:0] zv [8];
    logic        row_valid;
    logic        row_ready;
    logic        row_last;
    logic        sync_err;

    int unsigned n_vec;
    int unsigned n_err;

    serial_to_parallel #(
        .DATA_W (12),
        .LANES  (8)
    ) dut (
        .sys_clk       (clk),
        .sys_rst_n     (rst_n),
        .pix_data      (pix_data),
        .pix_valid     (pix_valid),
        .pix_sob       (pix_sob),
        .pix_ready     (pix_ready),
        .DCT_data_i_z0 (zv[0]),
        .DCT_data_i_z1 (zv[1]),
        .DCT_data_i_z2 (zv[2]),
        .DCT_data_i_z3 (zv[3]),
        .DCT_data_i_z4 (zv[4]),
        .DCT_data_i_z5 (zv[5]),
        .DCT_data_i_z6 (zv[6]),
        .DCT_data_i_z7 (zv[7]),
        .row_valid     (row_valid),
        .row_ready     (row_ready),
        .row_last      (row_last),
        .sync_err      (sync_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; returns on the next falling edge with outputs settled.
    task automatic drive(input logic v, input logic [11:0] d, input logic s);
        pix_valid = v;
        pix_data  = d;
        pix_sob   = s;
        @(negedge clk);
    endtask

    task automatic reset_dut(input logic rdy);
        rst_n     = 1'b0;
        pix_valid = 1'b0;
        pix_sob   = 1'b0;
        pix_data  = '0;
        row_ready = rdy;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;

        // Reset values, sampled while reset is still asserted
        rst_n     = 1'b0;
        pix_valid = 1'b0;
        pix_sob   = 1'b0;
        pix_data  = '0;
        row_ready = 1'b1;
        @(negedge clk);
        check("rst_rv", row_valid, 1'b0);
        check("rst_last", row_last, 1'b0);
        check("rst_serr", sync_err, 1'b0);
        check("rst_ready", pix_ready, 1'b1);
        check("rst_z0", zv[0], 12'h000);
        check("rst_z7", zv[7], 12'h000);

        // T1: single row with negative and max-positive samples
        begin
            logic [11:0] t1 [8];
            t1[0] = 12'hFFB; t1[1] = 12'd1; t1[2] = 12'd2; t1[3] = 12'd3;
            t1[4] = 12'd4;   t1[5] = 12'd5; t1[6] = 12'd6; t1[7] = 12'h7FF;
            reset_dut(1'b1);
            for (int k = 0; k < 8; k++) begin
                if (k == 7) check("t1_rv_early", row_valid, 1'b0);
                drive(1'b1, t1[k], k == 0);
            end
            check("t1_rv", row_valid, 1'b1);
            check("t1_z0", zv[0], 12'hFFB);
            check("t1_z3", zv[3], 12'd3);
            check("t1_z7", zv[7], 12'h7FF);
            check("t1_last", row_last, 1'b0);
            check("t1_serr", sync_err, 1'b0);
            drive(1'b0, 12'h000, 1'b0);
            check("t1_rv_drop", row_valid, 1'b0);
            check("t1_z0_hold", zv[0], 12'hFFB);
        end

        // T2: full 8x8 block, no stalls
        reset_dut(1'b1);
        for (int i = 0; i < 64; i++) begin
            check("t2_ready", pix_ready, 1'b1);
            drive(1'b1, 12'(100 + i), i == 0);
            check("t2_rv", row_valid, (i % 8) == 7);
            if ((i % 8) == 7) begin
                check("t2_last", row_last, i == 63);
                check("t2_z0", zv[0], 32'(12'(100 + i - 7)));
                check("t2_z7", zv[7], 32'(12'(100 + i)));
            end
            check("t2_serr", sync_err, 1'b0);
        end
        drive(1'b0, 12'h000, 1'b0);

        // T3: backpressure; the extra sample offered while stalled must be ignored
        reset_dut(1'b0);
        for (int c = 0; c < 20; c++) begin
            check("t3_ready", pix_ready, c < 16);
            if (c < 8)       drive(1'b1, 12'(200 + c), c == 0);
            else if (c < 16) drive(1'b1, 12'(300 + c - 8), 1'b0);
            else             drive(1'b1, 12'h400, 1'b0);
            if (c >= 7) begin
                check("t3_rv_hold", row_valid, 1'b1);
                check("t3_z0_hold", zv[0], 12'd200);
                check("t3_z7_hold", zv[7], 12'd207);
            end
        end
        row_ready = 1'b1;
        drive(1'b0, 12'h000, 1'b0);
        check("t3_rv_b", row_valid, 1'b1);
        check("t3_z0_b", zv[0], 12'd300);
        check("t3_z7_b", zv[7], 12'd307);
        check("t3_ready_back", pix_ready, 1'b1);
        drive(1'b0, 12'h000, 1'b0);
        check("t3_rv_end", row_valid, 1'b0);

        // T4: sob on the 4th sample of a row
        reset_dut(1'b1);
        drive(1'b1, 12'd500, 1'b1);
        check("t4_serr_first", sync_err, 1'b0);
        drive(1'b1, 12'd501, 1'b0);
        drive(1'b1, 12'd502, 1'b0);
        drive(1'b1, 12'd600, 1'b1);
        check("t4_serr_pulse", sync_err, 1'b1);
        for (int k = 1; k < 8; k++) begin
            drive(1'b1, 12'(600 + k), 1'b0);
            if (k == 1) check("t4_serr_clear", sync_err, 1'b0);
            if (k == 6) check("t4_rv_early", row_valid, 1'b0);
        end
        check("t4_rv", row_valid, 1'b1);
        check("t4_z0", zv[0], 12'd600);
        check("t4_z1", zv[1], 12'd601);
        check("t4_z7", zv[7], 12'd607);
        check("t4_last", row_last, 1'b0);

        // T5: reset in the middle of a partial row, with a stale row still on the outputs
        for (int k = 0; k < 5; k++) drive(1'b1, 12'(700 + k), 1'b0);
        check("t5_z0_stale", zv[0], 12'd600);
        pix_valid = 1'b0;
        rst_n     = 1'b0;
        #1;
        check("t5_rst_z0", zv[0], 12'h000);
        check("t5_rst_z7", zv[7], 12'h000);
        check("t5_rst_rv", row_valid, 1'b0);
        check("t5_rst_ready", pix_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if (k == 7) check("t5_rv_early", row_valid, 1'b0);
            drive(1'b1, 12'(800 + k), 1'b0);
        end
        check("t5_rv", row_valid, 1'b1);
        check("t5_z0", zv[0], 12'd800);
        check("t5_z7", zv[7], 12'd807);
        check("t5_serr", sync_err, 1'b0);
        drive(1'b0, 12'h000, 1'b0);

        // T6: consumer takes the held row on the same edge the next row completes
        reset_dut(1'b0);
        for (int k = 0; k < 8; k++) drive(1'b1, 12'(900 + k), k == 0);
        check("t6_rv_a", row_valid, 1'b1);
        check("t6_z0_a", zv[0], 12'd900);
        for (int k = 0; k < 8; k++) begin
            check("t6_ready", pix_ready, 1'b1);
            if (k == 7) row_ready = 1'b1;
            drive(1'b1, 12'(910 + k), 1'b0);
            check("t6_rv", row_valid, 1'b1);
            if (k < 7) check("t6_z0_hold", zv[0], 12'd900);
        end
        check("t6_z0_b", zv[0], 12'd910);
        check("t6_z7_b", zv[7], 12'd917);
        check("t6_ready_after", pix_ready, 1'b1);
        drive(1'b0, 12'h000, 1'b0);
        check("t6_rv_end", row_valid, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
